// File: rtl/ncl_count_capture.sv
// Clocked sink for the dual-rail counter digit ring. Each digit is
// synchronised into clk, and the DATA/NULL wavefronts are checked for
// completeness. Every wavefront must be seen twice in a row before it is
// acknowledged on sumCOMP. Each captured DATA wavefront is decoded to a
// binary count, which is then checked for +1 continuity.

// Per-digit two-flop synchroniser plus the local completeness terms.
module ncl_count_capture_digit (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] rail,
  output logic [1:0] s2,
  output logic       one_hot,
  output logic       nul,
  output logic       bad
);
  logic [1:0] s1_q, s1_d, s2_q, s2_d;

  // Next values for the synchroniser chain.
  always_comb begin
    s1_d = rail;
    s2_d = s1_q;
  end

  // Synchroniser register pair.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
    end
  end

  assign s2      = s2_q;
  assign one_hot = s2_q[1] ^ s2_q[0];
  assign nul     = ~|s2_q;
  assign bad     = &s2_q;
endmodule

module ncl_count_capture #(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 1024
) (
  input  logic               clk,
  input  logic               init,
  input  logic [2*WIDTH-1:0] sum,
  output logic               sumCOMP,
  output logic [WIDTH-1:0]   count,
  output logic               count_valid,
  output logic               seq_error,
  output logic               rail_error,
  output logic               stall
);
  typedef enum logic [1:0] {
    WAIT_DATA    = 2'd0,
    CONFIRM_DATA = 2'd1,
    WAIT_NULL    = 2'd2,
    CONFIRM_NULL = 2'd3
  } state_t;

  localparam logic [15:0] WD_MAX = 16'(TIMEOUT);

  // Reset is asserted asynchronously and released two clk edges after init
  // drops. Release is therefore synchronous to clk.
  logic [1:0] rst_q, rst_d;
  logic       rst;

  always_comb rst_d = {rst_q[0], 1'b0};

  // Deassert synchroniser for init.
  always_ff @(posedge clk or posedge init) begin
    if (init) rst_q <= 2'b11;
    else      rst_q <= rst_d;
  end

  assign rst = rst_q[1];

  // Per-digit synchronisers and completeness terms.
  logic [WIDTH-1:0][1:0] s2_w;
  logic [WIDTH-1:0]      one_hot_w, nul_w, bad_w;

  for (genvar i = 0; i < WIDTH; i++) begin : g_dig
    ncl_count_capture_digit u_dig (
      .clk     (clk),
      .rst     (rst),
      .rail    (sum[2*i+1:2*i]),
      .s2      (s2_w[i]),
      .one_hot (one_hot_w[i]),
      .nul     (nul_w[i]),
      .bad     (bad_w[i])
    );
  end

  logic [2*WIDTH-1:0] s2_flat;
  logic               full, empty, bad;

  assign s2_flat = s2_w;
  // Any 11 digit makes full false because that digit is not one-hot.
  assign full    = &one_hot_w;
  assign empty   = &nul_w;
  assign bad     = |bad_w;

  state_t             state_q, state_d;
  logic [2*WIDTH-1:0] cand_q, cand_d;
  logic [WIDTH-1:0]   count_q, count_d, decoded;
  logic               cv_q, cv_d, sc_q, sc_d;
  logic               seq_q, seq_d, rail_q, rail_d, stall_q, stall_d;
  logic               first_q, first_d;
  logic [15:0]        wd_q, wd_d;
  logic               wd_clr;

  // Rail 1 of each digit carries the binary value.
  always_comb begin
    decoded = '0;
    for (int i = 0; i < WIDTH; i++) decoded[i] = cand_q[2*i+1];
  end

  // Handshake FSM, continuity check, flags and watchdog.
  always_comb begin
    state_d = state_q;
    cand_d  = cand_q;
    count_d = count_q;
    cv_d    = 1'b0;
    sc_d    = sc_q;
    seq_d   = seq_q;
    rail_d  = rail_q | bad;
    first_d = first_q;
    wd_clr  = 1'b0;
    case (state_q)
      WAIT_DATA: begin
        if (full) begin
          cand_d  = s2_flat;
          state_d = CONFIRM_DATA;
        end
      end
      CONFIRM_DATA: begin
        // A wavefront that is still settling is rejected and sampled again.
        if (full && (s2_flat == cand_q)) begin
          count_d = decoded;
          cv_d    = 1'b1;
          sc_d    = 1'b1;
          wd_clr  = 1'b1;
          state_d = WAIT_NULL;
          if (first_q)                          first_d = 1'b0;
          else if (decoded != count_q + WIDTH'(1)) seq_d = 1'b1;
        end else begin
          state_d = WAIT_DATA;
        end
      end
      WAIT_NULL: begin
        if (empty) state_d = CONFIRM_NULL;
      end
      CONFIRM_NULL: begin
        if (empty) begin
          sc_d    = 1'b0;
          wd_clr  = 1'b1;
          state_d = WAIT_DATA;
        end else begin
          state_d = WAIT_NULL;
        end
      end
      default: state_d = WAIT_DATA;
    endcase
    if (wd_clr)              wd_d = '0;
    else if (wd_q != WD_MAX) wd_d = wd_q + 16'd1;
    else                     wd_d = wd_q;
    stall_d = stall_q | (wd_d == WD_MAX);
  end

  // State, datapath and sticky flag registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= WAIT_DATA;
      cand_q  <= '0;
      count_q <= '0;
      cv_q    <= 1'b0;
      sc_q    <= 1'b0;
      seq_q   <= 1'b0;
      rail_q  <= 1'b0;
      stall_q <= 1'b0;
      first_q <= 1'b1;
      wd_q    <= '0;
    end else begin
      state_q <= state_d;
      cand_q  <= cand_d;
      count_q <= count_d;
      cv_q    <= cv_d;
      sc_q    <= sc_d;
      seq_q   <= seq_d;
      rail_q  <= rail_d;
      stall_q <= stall_d;
      first_q <= first_d;
      wd_q    <= wd_d;
    end
  end

  assign sumCOMP     = sc_q;
  assign count       = count_q;
  assign count_valid = cv_q;
  assign seq_error   = seq_q;
  assign rail_error  = rail_q;
  assign stall       = stall_q;
endmodule

// File: doc/ncl_count_capture.md
Name: ncl_count_capture

Overview:
- Clocked consumer at the output of the dual-rail counter digit ring chain; it acts as the downstream stage of the digits' `sum` / `sumCOMP` port.
- Synchronises WIDTH dual-rail digits into the `clk` domain and detects DATA and NULL completeness.
- Drives the shared `sumCOMP` acknowledge and presents each completed count as a binary word.
- Checks count continuity and watches for a stalled ring.

Parameters:
- WIDTH, 32, number of counter digits (dual-rail pairs).
- TIMEOUT, 1024, clk cycles without a completed DATA or NULL wavefront before `stall` asserts; legal range 4..65535.

Ports:
- clk  input  1  sampling clock.
- init  input  1  asynchronous active-high reset; same net that initialises the ring.
- sum  input  2*WIDTH  dual-rail digits. Digit i = sum[2i+1:2i]; rail 1 = logic 1, rail 0 = logic 0; 00 = NULL; 11 = illegal.
- sumCOMP  output  1  completion acknowledge to all digits. 1 = DATA accepted, request NULL; 0 = NULL accepted, request DATA.
- count  output  WIDTH  last captured binary count.
- count_valid  output  1  one-cycle pulse when `count` updates.
- seq_error  output  1  sticky; a captured count was not previous+1 mod 2^WIDTH.
- rail_error  output  1  sticky; any digit sampled 11.
- stall  output  1  sticky; watchdog expired.

Behaviour:
- Reset (`init`=1, async): all synchroniser flops = 0, state = WAIT_DATA, sumCOMP=0, count=0, count_valid=0, all error flags=0, watchdog=0, first_flag=1. Release is synchronous to `clk` via internal 2-flop deassert sync.
- Synchroniser: 2 flops per rail (s1, s2). All completeness decisions use s2 only.
- Qualifiers, combinational on s2:
  - full = every digit has exactly one rail high.
  - empty = all rails 0.
  - bad = any digit 11.
- FSM states: WAIT_DATA, CONFIRM_DATA, WAIT_NULL, CONFIRM_NULL.
  - WAIT_DATA: if full, latch s2 into `cand` and go to CONFIRM_DATA.
  - CONFIRM_DATA: if full and s2==cand, then: count<=decoded cand, count_valid=1 for this cycle, sumCOMP<=1, go to WAIT_NULL. Else return to WAIT_DATA (skew / partial wavefront).
  - WAIT_NULL: if empty, go to CONFIRM_NULL.
  - CONFIRM_NULL: if empty, sumCOMP<=0 and go to WAIT_DATA. Else return to WAIT_NULL.
- sumCOMP is registered and changes only on the CONFIRM transitions. Never toggles twice within 3 cycles.
- Latency:
  - DATA wavefront stable at pins to count_valid: 4 clk (2 sync, 1 WAIT, 1 CONFIRM).
  - DATA stable to sumCOMP=1: same 4 clk.
  - NULL stable to sumCOMP=0: 4 clk.
- Decode: count[i] = cand[2i+1].
- Continuity check, on each capture:
  - If first_flag=1: no check; clear first_flag.
  - Else if decoded != count+1 mod 2^WIDTH: seq_error<=1.
  - Wrap 2^WIDTH-1 -> 0 is legal.
- rail_error: set on any cycle with bad in any state. The FSM ignores bad digits: full is false while any digit is 11.
- Watchdog:
  - Counts clk cycles, saturating; cleared on every CONFIRM_DATA and CONFIRM_NULL transition.
  - At TIMEOUT, stall<=1. The FSM keeps running.
- Flags are sticky until `init`.
- Reset mid-handshake: all state is cleared and sumCOMP forced to 0 immediately. The ring is also reset by the same `init`, so no recovery protocol is needed.
- count_valid and count update in the same cycle; count holds until the next capture.

Test Plan:
- Reset then handshake: assert init, release, drive all digits NULL -> sumCOMP=0, count=0, no flags. Drive DATA encoding 5 -> count_valid pulse exactly 4 clk later with count=5, sumCOMP=1 the same cycle. Drive NULL -> sumCOMP=0 4 clk later.
- Sequence: 10 wavefronts with values 5..14, each returned to NULL only after sumCOMP=1 -> 10 pulses, counts 5..14, seq_error=0. Then send 16 -> seq_error=1 and stays 1.
- Wrap: WIDTH=32; send 0xFFFFFFFF then 0x00000000 -> both captured, seq_error=0.
- Skew: digits arrive one per clk over 32 clk -> single count_valid only after the last digit plus 4 clk. No capture of partial values.
- Illegal rail: force digit 3 to 11 during a DATA wavefront -> rail_error=1, no capture. Clear digit 3 to legal -> capture proceeds.
- Stall and async reset: TIMEOUT=16, hold DATA without ever returning NULL -> stall=1 at cycle 16 after sumCOMP rose. Assert init mid-WAIT_NULL -> sumCOMP=0 asynchronously (before next clk edge), all flags cleared.
